corelet_ctrl: RTL and testbench

//  Sequencer that drives the corelet control pins in weight-stationary mode.
//  For each kernel position kij it performs these steps in order:

---
 rtl/corelet_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: weight-stationary sequencer for one corelet.
// For each kernel position it loads weights through L0 into the PE array,
// streams activations through L0 while executing, then drains the OFIFO into
// psum SRAM.  After the last kernel position it replays psum SRAM through the
// SFU (accumulate, then optional ReLU).
// Optional build macro: CORELET_CTRL_PERF_EN adds the perf_cycles busy counter.
module corelet_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int LEN_ONIJ = 16,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        inst,
  output logic              l0_wr,
  output logic              l0_rd,
  input  logic              l0_full,
  output logic              ofifo_rd,
  input  logic              ofifo_valid,
  output logic              xmem_en,
  output logic [ADDR_W-1:0] xmem_addr,
  output logic              pmem_wen,
  output logic              pmem_ren,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              accumulate,
  output logic              relu,
  output logic              out_valid
`ifdef CORELET_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  // Longest per-state count is the execute phase; the sum below is a safe
  // upper bound so no counter can ever wrap inside a state.
  localparam int A_EX_LEN = LEN_NIJ + row + col;
  localparam int CNT_MAX  = A_EX_LEN + LEN_NIJ + LEN_KIJ + row + col + 1;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int KIJ_W    = $clog2(LEN_KIJ + 1);
  localparam int O_W      = $clog2(LEN_ONIJ + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    W_RD    = 4'd1,
    W_LD    = 4'd2,
    W_FLUSH = 4'd3,
    A_RD    = 4'd4,
    A_EX    = 4'd5,
    DRAIN   = 4'd6,
    ACC     = 4'd7,
    DONE    = 4'd8
  } state_t;

  // All registered control outputs; drain qualifies the OFIFO/psum strobes,
  // which must follow ofifo_valid in the same cycle.
  typedef struct packed {
    logic              busy;
    logic              done;
    logic [1:0]        inst;
    logic              l0_wr;
    logic              l0_rd;
    logic              xmem_en;
    logic [ADDR_W-1:0] xmem_addr;
    logic              drain;
    logic              pmem_ren;
    logic [ADDR_W-1:0] pmem_addr;
    logic              accumulate;
    logic              relu;
    logic              out_valid;
  } outs_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [KIJ_W-1:0] kij_r, kij_s;
  logic [O_W-1:0]   o_r, o_s;
  logic             err_r, err_s;
  logic             relu_en_r, relu_en_s;
  logic             abort_s;
  outs_t            outs_r, outs_s;

  // Linear SRAM address a*b+c truncated to the address width.
  function automatic logic [ADDR_W-1:0] addr_of(input int a, input int b, input int c);
    return ADDR_W'(a * b + c);
  endfunction

  // An L0 write into a full L0 aborts the whole run.
  assign abort_s = outs_r.l0_wr & l0_full;

  // Next-state, counter and sticky-error logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    kij_s     = kij_r;
    o_s       = o_r;
    err_s     = err_r;
    relu_en_s = relu_en_r;
    if (abort_s) begin
      state_s = IDLE;
      cnt_s   = '0;
      kij_s   = '0;
      o_s     = '0;
      err_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s   = W_RD;
            cnt_s     = '0;
            kij_s     = '0;
            o_s       = '0;
            err_s     = 1'b0;
            relu_en_s = relu_en;
          end else begin
            state_s = IDLE;
          end
        end
        W_RD: begin
          // row reads plus one trailing cycle for the delayed L0 write
          if (cnt_r == CNT_W'(row)) begin
            state_s = W_LD;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        W_LD: begin
          if (cnt_r == CNT_W'(row - 1)) begin
            state_s = W_FLUSH;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        W_FLUSH: begin
          if (cnt_r == CNT_W'(row + col - 1)) begin
            state_s = A_RD;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        A_RD: begin
          if (cnt_r == CNT_W'(LEN_NIJ)) begin
            state_s = A_EX;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        A_EX: begin
          if (cnt_r == CNT_W'(A_EX_LEN - 1)) begin
            state_s = DRAIN;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DRAIN: begin
          // cnt counts pops only, so stalls never disturb the psum address
          if (ofifo_valid) begin
            if (cnt_r == CNT_W'(LEN_NIJ - 1)) begin
              cnt_s = '0;
              kij_s = kij_r + KIJ_W'(1);
              if (int'(kij_r) + 1 < LEN_KIJ) begin
                state_s = W_RD;
              end else begin
                state_s = ACC;
                o_s     = '0;
              end
            end else begin
              cnt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ACC: begin
          // o == LEN_ONIJ is a one-cycle tail carrying the last out_valid
          if (o_r == O_W'(LEN_ONIJ)) begin
            state_s = DONE;
            cnt_s   = '0;
          end else if (cnt_r == CNT_W'(LEN_KIJ)) begin
            cnt_s = '0;
            o_s   = o_r + O_W'(1);
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_s = IDLE;
          kij_s   = '0;
          o_s     = '0;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so every strobe comes straight from a flop
  always_comb begin
    outs_s      = '0;
    outs_s.busy = (state_s != IDLE);
    case (state_s)
      W_RD: begin
        if (cnt_s < CNT_W'(row)) begin
          outs_s.xmem_en   = 1'b1;
          outs_s.xmem_addr = addr_of(int'(kij_s), row, int'(cnt_s));
        end else begin
          outs_s.xmem_en = 1'b0;
        end
        outs_s.l0_wr = (cnt_s != '0);
      end
      W_LD: begin
        outs_s.l0_rd = 1'b1;
        outs_s.inst  = 2'b01;
      end
      A_RD: begin
        if (cnt_s < CNT_W'(LEN_NIJ)) begin
          outs_s.xmem_en   = 1'b1;
          outs_s.xmem_addr = addr_of(LEN_KIJ, row, int'(cnt_s));
        end else begin
          outs_s.xmem_en = 1'b0;
        end
        outs_s.l0_wr = (cnt_s != '0);
      end
      A_EX: begin
        if (cnt_s < CNT_W'(LEN_NIJ)) begin
          outs_s.l0_rd = 1'b1;
          outs_s.inst  = 2'b10;
        end else begin
          outs_s.inst = 2'b00;
        end
      end
      DRAIN: begin
        outs_s.drain     = 1'b1;
        outs_s.pmem_addr = addr_of(int'(kij_s), LEN_NIJ, int'(cnt_s));
      end
      ACC: begin
        if ((o_s < O_W'(LEN_ONIJ)) && (cnt_s < CNT_W'(LEN_KIJ))) begin
          outs_s.pmem_ren  = 1'b1;
          outs_s.pmem_addr = addr_of(int'(cnt_s), LEN_NIJ, int'(o_s));
        end else begin
          outs_s.pmem_ren = 1'b0;
        end
        outs_s.accumulate = (cnt_s != '0);
        if ((cnt_s == '0) && (o_s != '0)) begin
          outs_s.out_valid = 1'b1;
          outs_s.relu      = relu_en_s;
        end else begin
          outs_s.out_valid = 1'b0;
        end
      end
      DONE: begin
        outs_s.done = 1'b1;
      end
      default: begin
        outs_s.busy = (state_s != IDLE);
      end
    endcase
  end

  // State, counters, sticky error and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      kij_r     <= '0;
      o_r       <= '0;
      err_r     <= 1'b0;
      relu_en_r <= 1'b0;
      outs_r    <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      kij_r     <= kij_s;
      o_r       <= o_s;
      err_r     <= err_s;
      relu_en_r <= relu_en_s;
      outs_r    <= outs_s;
    end
  end

  assign busy       = outs_r.busy;
  assign done       = outs_r.done;
  assign err        = err_r;
  assign inst       = outs_r.inst;
  assign l0_wr      = outs_r.l0_wr;
  assign l0_rd      = outs_r.l0_rd;
  assign xmem_en    = outs_r.xmem_en;
  assign xmem_addr  = outs_r.xmem_addr;
  assign ofifo_rd   = outs_r.drain & ofifo_valid;
  assign pmem_wen   = outs_r.drain & ofifo_valid;
  assign pmem_ren   = outs_r.pmem_ren;
  assign pmem_addr  = outs_r.pmem_addr;
  assign accumulate = outs_r.accumulate;
  assign relu       = outs_r.relu;
  assign out_valid  = outs_r.out_valid;

`ifdef CORELET_CTRL_PERF_EN
  logic [31:0] perf_r;

  // Busy-cycle counter: cleared by an accepted start, saturating, holds when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_r <= 32'd0;
    end else if ((state_r == IDLE) && start) begin
      perf_r <= 32'd0;
    end else if ((state_r != IDLE) && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_cycles = perf_r;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: self-checking bench for corelet_ctrl.
// Each cycle's outputs are sampled on the falling edge and folded into event
// counts and address queues, which each test compares against a reference
// built from the sequencing rules (address lists and event totals).
module tb_corelet_ctrl;
  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int KIJ  = 9;
  localparam int NIJ  = 36;
  localparam int ONIJ = 16;
  localparam int AW   = 11;

  logic          clk = 1'b0;
  logic          reset, start, relu_en, l0_full, ofifo_valid;
  logic          busy, done, err, l0_wr, l0_rd, ofifo_rd, xmem_en;
  logic          pmem_wen, pmem_ren, accumulate, relu, out_valid;
  logic [1:0]    inst;
  logic [AW-1:0] xmem_addr, pmem_addr;
`ifdef CORELET_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  corelet_ctrl #(.row(ROW), .col(COL), .LEN_KIJ(KIJ), .LEN_NIJ(NIJ),
                 .LEN_ONIJ(ONIJ), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done), .err(err), .inst(inst),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_full(l0_full),
    .ofifo_rd(ofifo_rd), .ofifo_valid(ofifo_valid),
    .xmem_en(xmem_en), .xmem_addr(xmem_addr),
    .pmem_wen(pmem_wen), .pmem_ren(pmem_ren), .pmem_addr(pmem_addr),
    .accumulate(accumulate), .relu(relu), .out_valid(out_valid)
`ifdef CORELET_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp, n_err;
  int valid_mode;  // 0: ofifo_valid tied high, 1: random
  bit full_drv;
  int n_wlrd, n_axrd, n_l0rd_bad, n_l0wr, n_l0wr_bad, n_rd_bad, n_acc, n_acc_bad;
  int n_ov, n_ov_bad, n_relu, n_relu_bad, n_done, n_busy, n_act_rd;
  bit prev_xen, prev_ren, prev_acc;
  int xq[$], wq[$], rq[$], exp_x[$], exp_w[$], exp_r[$];

  // Index of first difference between two queues, -1 when identical.
  function automatic int q_diff(input int a[$], input int b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic build_model();
    for (int k = 0; k < KIJ; k++) begin
      for (int i = 0; i < ROW; i++) exp_x.push_back(k * ROW + i);
      for (int n = 0; n < NIJ; n++) exp_x.push_back(KIJ * ROW + n);
      for (int m = 0; m < NIJ; m++) exp_w.push_back(k * NIJ + m);
    end
    for (int o = 0; o < ONIJ; o++)
      for (int k = 0; k < KIJ; k++) exp_r.push_back(k * NIJ + o);
  endtask

  task automatic clear_stats();
    n_wlrd = 0; n_axrd = 0; n_l0rd_bad = 0; n_l0wr = 0; n_l0wr_bad = 0;
    n_rd_bad = 0; n_acc = 0; n_acc_bad = 0; n_ov = 0; n_ov_bad = 0;
    n_relu = 0; n_relu_bad = 0; n_done = 0; n_busy = 0; n_act_rd = 0;
    prev_xen = 1'b0; prev_ren = 1'b0; prev_acc = 1'b0;
    xq.delete(); wq.delete(); rq.delete();
  endtask

  // One clock: drive inputs just after the rising edge, sample on the falling edge.
  task automatic step(input bit st);
    @(posedge clk);
    #1;
    start       = st;
    ofifo_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    l0_full     = full_drv;
    @(negedge clk);
    if (busy) n_busy++;
    if (l0_rd && inst == 2'b01) n_wlrd++;
    else if (l0_rd && inst == 2'b10) n_axrd++;
    else if (l0_rd) n_l0rd_bad++;
    if (inst != 2'b00 && !l0_rd) n_l0rd_bad++;
    if (xmem_en) begin
      xq.push_back(int'(xmem_addr));
      if (int'(xmem_addr) >= KIJ * ROW) n_act_rd++;
    end
    if (l0_wr) n_l0wr++;
    if (l0_wr != prev_xen) n_l0wr_bad++;
    if ((ofifo_rd != pmem_wen) || (ofifo_rd && !ofifo_valid)) n_rd_bad++;
    if (pmem_wen) wq.push_back(int'(pmem_addr));
    if (pmem_ren) rq.push_back(int'(pmem_addr));
    if (accumulate) n_acc++;
    if (accumulate != prev_ren) n_acc_bad++;
    if (out_valid) n_ov++;
    if (out_valid != (prev_acc && !accumulate)) n_ov_bad++;
    if (relu) n_relu++;
    if (relu && !out_valid) n_relu_bad++;
    if (done) n_done++;
    prev_xen = xmem_en;
    prev_ren = pmem_ren;
    prev_acc = accumulate;
  endtask

  task automatic run_to_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step(1'b0);
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, done, err, inst, l0_wr, l0_rd, ofifo_rd, xmem_en, xmem_addr, pmem_wen,
         pmem_ren, pmem_addr, accumulate, relu, out_valid} !== '0) begin
      n_err++; $display("FAIL reset_outputs: some output nonzero during reset, want all 0");
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    step(1'b0);
    step(1'b0);
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: busy=%b err=%b done=%b, want 0 0 0", busy, err, done);
    end
  endtask

  task automatic test_full_run(input bit r);
    bit to;
    int d;
    clear_stats();
    valid_mode = 0;
    relu_en = r;
    step(1'b1);
    run_to_idle(4000, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL full_timeout: busy never dropped (relu_en=%0d)", r); end
    n_cmp++; if (n_wlrd != KIJ * ROW) begin n_err++; $display("FAIL full_kload: got %0d, want %0d", n_wlrd, KIJ * ROW); end
    n_cmp++; if (n_axrd != KIJ * NIJ) begin n_err++; $display("FAIL full_exec: got %0d, want %0d", n_axrd, KIJ * NIJ); end
    n_cmp++; if (n_l0rd_bad != 0) begin n_err++; $display("FAIL full_inst: %0d bad l0_rd/inst cycles, want 0", n_l0rd_bad); end
    d = q_diff(xq, exp_x);
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL full_xmem_seq: differs at %0d (got %0d reads, want %0d)", d, xq.size(), exp_x.size()); end
    n_cmp++; if (n_l0wr != exp_x.size() || n_l0wr_bad != 0) begin
      n_err++; $display("FAIL full_l0wr: got %0d writes %0d misaligned, want %0d 0", n_l0wr, n_l0wr_bad, exp_x.size()); end
    d = q_diff(wq, exp_w);
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL full_pmem_wr: differs at %0d (got %0d, want %0d)", d, wq.size(), exp_w.size()); end
    d = q_diff(rq, exp_r);
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL full_pmem_rd: differs at %0d (got %0d, want %0d)", d, rq.size(), exp_r.size()); end
    n_cmp++; if (n_acc != ONIJ * KIJ || n_acc_bad != 0) begin
      n_err++; $display("FAIL full_acc: got %0d (%0d misaligned), want %0d", n_acc, n_acc_bad, ONIJ * KIJ); end
    n_cmp++; if (n_ov != ONIJ || n_ov_bad != 0) begin
      n_err++; $display("FAIL full_out_valid: got %0d (%0d misplaced), want %0d", n_ov, n_ov_bad, ONIJ); end
    n_cmp++; if (n_relu != (r ? ONIJ : 0) || n_relu_bad != 0) begin
      n_err++; $display("FAIL full_relu: got %0d (%0d stray), want %0d", n_relu, n_relu_bad, r ? ONIJ : 0); end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL full_done: got %0d, want 1", n_done); end
    n_cmp++; if (n_rd_bad != 0) begin n_err++; $display("FAIL full_ofifo_rd: %0d bad cycles, want 0", n_rd_bad); end
  endtask

  task automatic test_drain_stall();
    bit to;
    int d;
    clear_stats();
    valid_mode = 1;
    relu_en = 1'($urandom_range(0, 1));
    step(1'b1);
    run_to_idle(8000, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL stall_timeout: busy never dropped"); end
    n_cmp++; if (n_rd_bad != 0) begin n_err++; $display("FAIL stall_ofifo_rd: %0d cycles popped without valid, want 0", n_rd_bad); end
    d = q_diff(wq, exp_w);
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL stall_pmem_wr: differs at %0d (got %0d, want %0d)", d, wq.size(), exp_w.size()); end
    n_cmp++; if (n_done != 1 || n_ov != ONIJ) begin
      n_err++; $display("FAIL stall_finish: done=%0d out_valid=%0d, want 1 %0d", n_done, n_ov, ONIJ); end
    valid_mode = 0;
  endtask

  task automatic test_start_ignored();
    bit to;
    int d;
    clear_stats();
    valid_mode = 0;
    relu_en = 1'b0;
    step(1'b1);
    repeat (300) step(1'b0);
    step(1'b1);
    run_to_idle(4000, to);
    d = q_diff(xq, exp_x);
    n_cmp++; if (to || d != -1) begin n_err++; $display("FAIL ignore_xmem: timeout=%0d diff at %0d, want 0 -1", to, d); end
    n_cmp++; if (n_done != 1 || n_wlrd != KIJ * ROW) begin
      n_err++; $display("FAIL ignore_done: done=%0d kload=%0d, want 1 %0d", n_done, n_wlrd, KIJ * ROW); end
`ifdef CORELET_CTRL_PERF_EN
    n_cmp++; if (perf_cycles !== 32'(n_busy)) begin
      n_err++; $display("FAIL perf_count: got %0d, want %0d", perf_cycles, n_busy); end
    repeat (5) step(1'b0);
    n_cmp++; if (perf_cycles !== 32'(n_busy)) begin
      n_err++; $display("FAIL perf_hold: got %0d, want %0d", perf_cycles, n_busy); end
`endif
  endtask

  task automatic test_abort();
    bit to;
    clear_stats();
    valid_mode = 0;
    relu_en = 1'b0;
    step(1'b1);
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step(1'b0);
      if (n_act_rd >= 2 * NIJ + 5) begin to = 1'b0; break; end
    end
    n_cmp++; if (to) begin n_err++; $display("FAIL abort_reach: A_RD of kij=2 not reached"); end
    full_drv = 1'b1;
    step(1'b0);
    n_cmp++; if (busy !== 1'b1 || l0_wr !== 1'b1) begin
      n_err++; $display("FAIL abort_pre: busy=%b l0_wr=%b, want 1 1", busy, l0_wr); end
    step(1'b0);
    full_drv = 1'b0;
    n_cmp++; if (busy !== 1'b0 || err !== 1'b1 || xmem_en !== 1'b0 || l0_wr !== 1'b0) begin
      n_err++; $display("FAIL abort_stop: busy=%b err=%b xmem_en=%b l0_wr=%b, want 0 1 0 0", busy, err, xmem_en, l0_wr); end
    repeat (20) step(1'b0);
    n_cmp++; if (n_done != 0 || err !== 1'b1) begin
      n_err++; $display("FAIL abort_sticky: done=%0d err=%b, want 0 1", n_done, err); end
    clear_stats();
    step(1'b1);
    step(1'b0);
    n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL abort_restart: err=%b busy=%b, want 0 1", err, busy); end
    run_to_idle(4000, to);
    n_cmp++; if (to || n_done != 1) begin n_err++; $display("FAIL abort_rerun: timeout=%0d done=%0d, want 0 1", to, n_done); end
  endtask

  task automatic test_reset_in_acc();
    bit to;
    int d;
    clear_stats();
    valid_mode = 0;
    relu_en = 1'b1;
    step(1'b1);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step(1'b0);
      if (rq.size() >= 40) begin to = 1'b0; break; end
    end
    n_cmp++; if (to) begin n_err++; $display("FAIL acc_reach: ACC phase not reached"); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, err, inst, l0_wr, l0_rd, ofifo_rd, xmem_en, xmem_addr, pmem_wen,
         pmem_ren, pmem_addr, accumulate, relu, out_valid} !== '0) begin
      n_err++; $display("FAIL acc_reset: outputs nonzero in reset cycle (busy=%b ren=%b acc=%b), want all 0", busy, pmem_ren, accumulate); end
    @(negedge clk);
    #2 reset = 1'b0;
    clear_stats();
    step(1'b1);
    run_to_idle(4000, to);
    d = q_diff(rq, exp_r);
    n_cmp++; if (to || n_done != 1 || d != -1 || n_relu != ONIJ) begin
      n_err++; $display("FAIL acc_rerun: timeout=%0d done=%0d rdiff=%0d relu=%0d, want 0 1 -1 %0d", to, n_done, d, n_relu, ONIJ); end
  endtask

  initial begin
    bit r0;
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b0;
    valid_mode = 0; full_drv = 1'b0;
    build_model();
    clear_stats();
    test_reset();
    r0 = 1'($urandom_range(0, 1));
    test_full_run(r0);
    test_full_run(!r0);
    test_drain_stall();
    test_start_ignored();
    test_abort();
    test_reset_in_acc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
